// File: rtl/fp16_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : fp16_result_packer
// Purpose  : Packs FP16 results into wide words, buffers them in a FWFT FIFO.
// Revision : 1.0
// ============================================================================
module fp16_result_packer #(
    parameter int PACK_N     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [15:0]           i_fp16_result,
    input  logic                  i_valid,
    input  logic                  i_last,
    output logic                  o_ready,
    output logic [16*PACK_N-1:0]  o_data,
    output logic [PACK_N-1:0]     o_data_strb,
    output logic                  o_data_last,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    output logic [15:0]           o_result_count,
    output logic                  o_overrun
);

    localparam int c_LANE_W = $clog2(PACK_N);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_WORD_W = 16 * PACK_N;

    logic [c_LANE_W-1:0] lane_ptr_q, lane_ptr_d;
    logic [c_WORD_W-1:0] asm_data_q, asm_data_d;
    logic [PACK_N-1:0]   asm_strb_q, asm_strb_d;
    logic [c_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [15:0]         result_cnt_q, result_cnt_d;
    logic                overrun_q, overrun_d;

    logic [c_WORD_W-1:0] mem_data_q [FIFO_DEPTH];
    logic [PACK_N-1:0]   mem_strb_q [FIFO_DEPTH];
    logic                mem_last_q [FIFO_DEPTH];

    logic                w_accept;
    logic                w_commit;
    logic                w_pop;
    logic [c_WORD_W-1:0] w_word;
    logic [PACK_N-1:0]   w_strb;

    assign o_ready      = (fifo_cnt_q != c_CNT_W'(FIFO_DEPTH));
    assign o_data_valid = (fifo_cnt_q != '0);
    assign w_accept     = i_valid & o_ready;
    assign w_commit     = w_accept & ((lane_ptr_q == c_LANE_W'(PACK_N - 1)) | i_last);
    assign w_pop        = o_data_valid & i_data_ready;

    // Assembled word including the lane being written this cycle; this is
    // what gets pushed when the word commits.
    always_comb begin
        w_word = asm_data_q;
        w_strb = asm_strb_q;
        for (int k = 0; k < PACK_N; k++) begin
            if (lane_ptr_q == c_LANE_W'(k)) begin
                w_word[16*k +: 16] = i_fp16_result;
                w_strb[k]          = 1'b1;
            end
        end
    end

    always_comb begin
        lane_ptr_d   = lane_ptr_q;
        asm_data_d   = asm_data_q;
        asm_strb_d   = asm_strb_q;
        result_cnt_d = result_cnt_q;
        overrun_d    = overrun_q | (i_valid & ~o_ready);
        if (w_accept) begin
            result_cnt_d = result_cnt_q + 16'd1;
            if (w_commit) begin
                lane_ptr_d = '0;
                asm_data_d = '0;
                asm_strb_d = '0;
            end else begin
                lane_ptr_d = lane_ptr_q + c_LANE_W'(1);
                asm_data_d = w_word;
                asm_strb_d = w_strb;
            end
        end
    end

    always_comb begin
        wr_ptr_d   = w_commit ? wr_ptr_q + c_PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = w_pop    ? rd_ptr_q + c_PTR_W'(1) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        case ({w_commit, w_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + c_CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - c_CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lane_ptr_q   <= '0;
            asm_data_q   <= '0;
            asm_strb_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            result_cnt_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            lane_ptr_q   <= lane_ptr_d;
            asm_data_q   <= asm_data_d;
            asm_strb_q   <= asm_strb_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            result_cnt_q <= result_cnt_d;
            overrun_q    <= overrun_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever empty.
    always_ff @(posedge i_clk) begin
        if (w_commit && !i_reset) begin
            mem_data_q[wr_ptr_q] <= w_word;
            mem_strb_q[wr_ptr_q] <= w_strb;
            mem_last_q[wr_ptr_q] <= i_last;
        end
    end

    assign o_data         = o_data_valid ? mem_data_q[rd_ptr_q] : '0;
    assign o_data_strb    = o_data_valid ? mem_strb_q[rd_ptr_q] : '0;
    assign o_data_last    = o_data_valid ? mem_last_q[rd_ptr_q] : 1'b0;
    assign o_result_count = result_cnt_q;
    assign o_overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fp16_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp16_result_packer
// Purpose  : Self-checking bench for fp16_result_packer against a queue model.
// Revision : 1.0
// ============================================================================
module tb_fp16_result_packer;

    localparam int PN = 8;
    localparam int FD = 4;
    localparam int W  = 16 * PN;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   res;
    logic          valid;
    logic          last;
    logic          dready;
    logic          o_ready;
    logic [W-1:0]  o_data;
    logic [PN-1:0] o_strb;
    logic          o_dlast;
    logic          o_dvalid;
    logic [15:0]   o_count;
    logic          o_ovr;

    always #5 clk = ~clk;

    fp16_result_packer #(.PACK_N(PN), .FIFO_DEPTH(FD)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_fp16_result  (res),
        .i_valid        (valid),
        .i_last         (last),
        .o_ready        (o_ready),
        .o_data         (o_data),
        .o_data_strb    (o_strb),
        .o_data_last    (o_dlast),
        .o_data_valid   (o_dvalid),
        .i_data_ready   (dready),
        .o_result_count (o_count),
        .o_overrun      (o_ovr)
    );

    typedef struct {
        logic [W-1:0]  data;
        logic [PN-1:0] strb;
        logic          last;
    } word_t;

    typedef struct {
        logic [15:0] res;
        logic        last;
        logic        exp_dv;
        logic [15:0] exp_cnt;
    } vec_t;

    word_t       mq[$];
    logic [15:0] part[$];
    logic [15:0] m_count;
    logic        m_ovr;
    int          pops_seen = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a queue of packed words and a list of pending results.
    always @(posedge clk) begin
        bit    m_ready;
        bit    m_pop;
        word_t w;
        if (rst) begin
            mq.delete();
            part.delete();
            m_count = 16'd0;
            m_ovr   = 1'b0;
        end else begin
            m_ready = (mq.size() != FD);
            m_pop   = (mq.size() != 0) && dready;
            if (valid && !m_ready) m_ovr = 1'b1;
            if (m_pop) begin
                void'(mq.pop_front());
                pops_seen++;
            end
            if (valid && m_ready) begin
                part.push_back(res);
                m_count = m_count + 16'd1;
                if (part.size() == PN || last) begin
                    w.data = '0;
                    w.strb = '0;
                    for (int k = 0; k < part.size(); k++) begin
                        w.data[16*k +: 16] = part[k];
                        w.strb[k]          = 1'b1;
                    end
                    w.last = last;
                    mq.push_back(w);
                    part.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        word_t h;
        if (chk_en) begin
            h = '{data: '0, strb: '0, last: 1'b0};
            if (mq.size() != 0) h = mq[0];
            chk("m_ready",  W'(o_ready),  W'(mq.size() != FD));
            chk("m_dvalid", W'(o_dvalid), W'(mq.size() != 0));
            chk("m_data",   o_data,       h.data);
            chk("m_strb",   W'(o_strb),   W'(h.strb));
            chk("m_dlast",  W'(o_dlast),  W'(h.last));
            chk("m_count",  W'(o_count),  W'(m_count));
            chk("m_ovr",    W'(o_ovr),    W'(m_ovr));
        end
    end

    initial begin
        vec_t        tbl[PN];
        logic [15:0] fw_vals[PN];
        int          sent;
        int          pops_base;

        fw_vals = '{16'h3C00, 16'h3E00, 16'h4000, 16'h4200,
                    16'h4400, 16'h4500, 16'h4600, 16'h4700};
        for (int i = 0; i < PN; i++) begin
            tbl[i].res     = fw_vals[i];
            tbl[i].last    = (i == PN - 1);
            tbl[i].exp_dv  = (i == PN - 1);
            tbl[i].exp_cnt = 16'(i + 1);
        end

        rst = 1'b1; valid = 1'b0; last = 1'b0; res = 16'h0; dready = 1'b1;
        tick();
        tick();
        chk("rst_ready",  W'(o_ready),  W'(1));
        chk("rst_dvalid", W'(o_dvalid), W'(0));
        chk("rst_data",   o_data,       '0);
        chk("rst_strb",   W'(o_strb),   W'(0));
        chk("rst_dlast",  W'(o_dlast),  W'(0));
        chk("rst_count",  W'(o_count),  W'(0));
        chk("rst_ovr",    W'(o_ovr),    W'(0));
        rst = 1'b0;
        chk_en = 1'b1;

        // Full word from the table, last on the eighth result.
        for (int i = 0; i < PN; i++) begin
            valid = 1'b1; res = tbl[i].res; last = tbl[i].last;
            tick();
            chk("fw_dvalid", W'(o_dvalid), W'(tbl[i].exp_dv));
            chk("fw_count",  W'(o_count),  W'(tbl[i].exp_cnt));
        end
        chk("fw_lane0", W'(o_data[15:0]),    W'(16'h3C00));
        chk("fw_lane7", W'(o_data[127:112]), W'(16'h4700));
        chk("fw_strb",  W'(o_strb),          W'(8'hFF));
        chk("fw_last",  W'(o_dlast),         W'(1));
        valid = 1'b0; last = 1'b0;
        tick();

        // Short tile of three, then a single-result tile restarting at lane 0.
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; res = 16'(16'h1111 * (i + 1)); last = (i == 2);
            tick();
        end
        chk("st_strb", W'(o_strb),         W'(8'h07));
        chk("st_lo",   W'(o_data[47:0]),   W'(48'h3333_2222_1111));
        chk("st_hi",   W'(o_data[127:48]), W'(0));
        chk("st_last", W'(o_dlast),        W'(1));
        valid = 1'b0; last = 1'b0;
        tick();
        valid = 1'b1; res = 16'h5555; last = 1'b1;
        tick();
        chk("st2_strb",  W'(o_strb),       W'(8'h01));
        chk("st2_lane0", W'(o_data[15:0]), W'(16'h5555));
        valid = 1'b0; last = 1'b0;
        tick();

        // Backpressure: fill the FIFO, overrun on the 33rd, single pop.
        dready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            valid = 1'b1; res = 16'(16'h1000 + i);
            tick();
            chk("bp_ready", W'(o_ready), W'(i != 31));
        end
        res = 16'hDEAD;
        tick();
        valid = 1'b0;
        chk("bp_ovr",   W'(o_ovr),   W'(1));
        chk("bp_count", W'(o_count), W'(16'd44));
        dready = 1'b1;
        tick();
        chk("bp_ready_after_pop", W'(o_ready), W'(1));
        dready = 1'b0;
        tick();
        chk("bp_head", W'(o_data[15:0]), W'(16'h1008));
        dready = 1'b1;
        for (int t = 0; t < 20 && o_dvalid; t++) tick();
        chk("bp_drain", W'(o_dvalid), W'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("bp_ovr_clear", W'(o_ovr), W'(0));

        // Simultaneous push and pop with two words buffered.
        dready = 1'b0;
        for (int i = 0; i < 23; i++) begin
            valid = 1'b1; res = (i < 16) ? 16'(16'h2000 + i) : 16'(16'h2100 + i - 16);
            tick();
        end
        dready = 1'b1; res = 16'h2107;
        tick();
        valid = 1'b0;
        chk("pp_dvalid", W'(o_dvalid),      W'(1));
        chk("pp_head",   W'(o_data[15:0]),  W'(16'h2008));
        tick();
        chk("pp_dvalid2", W'(o_dvalid),     W'(1));
        chk("pp_head2",   W'(o_data[15:0]), W'(16'h2100));
        chk("pp_head2_7", W'(o_data[127:112]), W'(16'h2107));
        tick();
        chk("pp_empty", W'(o_dvalid), W'(0));

        // Reset mid-word discards the partial word.
        dready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1; res = 16'(16'h3000 + i);
            tick();
        end
        valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rm_dvalid", W'(o_dvalid), W'(0));
        chk("rm_count",  W'(o_count),  W'(0));
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1; res = 16'(16'hA000 + i);
            tick();
        end
        valid = 1'b0;
        chk("rm_strb",  W'(o_strb),          W'(8'hFF));
        chk("rm_lane0", W'(o_data[15:0]),    W'(16'hA000));
        chk("rm_lane7", W'(o_data[127:112]), W'(16'hA007));
        chk("rm_count8", W'(o_count),        W'(8));
        dready = 1'b1;
        tick();

        // Random backpressure over 20 words with a well-behaved upstream.
        pops_base = pops_seen;
        sent = 0;
        for (int t = 0; t < 3000 && sent < 160; t++) begin
            dready = $urandom_range(0, 1) == 1;
            if (o_ready && $urandom_range(0, 3) != 0) begin
                valid = 1'b1; res = 16'($urandom); sent++;
            end else begin
                valid = 1'b0;
            end
            tick();
        end
        valid = 1'b0;
        dready = 1'b1;
        for (int t = 0; t < 20 && o_dvalid; t++) tick();
        chk("rnd_sent",  W'(sent),                   W'(160));
        chk("rnd_pops",  W'(pops_seen - pops_base),  W'(20));
        chk("rnd_empty", W'(o_dvalid),               W'(0));
        chk("rnd_ovr",   W'(o_ovr),                  W'(0));
        chk("rnd_count", W'(o_count),                W'(16'd168));

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
